// File: rtl/fft16_pkg.sv
// fft16_pkg: shared widths and loader state encoding for the fft16 front end.
package fft16_pkg;
    localparam int FFT16_DW = 24;
    localparam int FFT16_N  = 16;
    localparam int FFT16_CW = 4;
    typedef enum logic {FILL, HOLD} state_t;
endpackage

// File: rtl/fft16_input_loader_if.sv
// fft16_input_loader_if: sample stream in, 16-sample frame bus out.
interface fft16_input_loader_if
    import fft16_pkg::*;
#(
    parameter int DW = FFT16_DW,
    parameter int N  = FFT16_N
);
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_real;
    logic [DW-1:0] s_imag;
    logic          s_last;
    logic          fft_ready;
    logic [N*DW-1:0] frame_real;
    logic [N*DW-1:0] frame_imag;
    logic          frame_valid;
    logic          frame_err;
    modport master (
        output s_valid, s_real, s_imag, s_last, fft_ready,
        input  s_ready, frame_real, frame_imag, frame_valid, frame_err
    );
    modport slave (
        input  s_valid, s_real, s_imag, s_last, fft_ready,
        output s_ready, frame_real, frame_imag, frame_valid, frame_err
    );
endinterface

// File: rtl/fft16_input_loader.sv
// fft16_input_loader: collects 16 complex samples and presents them as a held
// parallel frame for fft_0, with one-cycle frame_valid / frame_err pulses.
module fft16_input_loader
    import fft16_pkg::*;
#(
    parameter int DW = FFT16_DW,
    parameter int N  = FFT16_N,
    parameter int CW = FFT16_CW
) (
    input logic clk,
    input logic rst,
    fft16_input_loader_if.slave bus
);
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [DW-1:0] wr_real [N];
    logic [DW-1:0] wr_imag [N];
    logic [N*DW-1:0] ld_real, ld_imag;
    logic accept, last_slot, done, abort, misalign, xfer_fill, xfer_hold;

    always_ff @(posedge clk) begin
        if (!rst) state <= FILL;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (state == FILL) state_nx = (done && !bus.fft_ready) ? HOLD : FILL;
        else               state_nx = bus.fft_ready ? FILL : HOLD;
    end

    always_comb begin
        bus.s_ready = rst && (state == FILL);
        accept      = bus.s_valid && bus.s_ready;
        last_slot   = cnt == CW'(N - 1);
        done        = accept && last_slot;
        abort       = accept && !last_slot && bus.s_last;
        misalign    = done && !bus.s_last;
        xfer_fill   = done && bus.fft_ready;
        xfer_hold   = (state == HOLD) && bus.fft_ready;
    end

    // On a FILL-side transfer the 16th sample bypasses the write bank.
    always_comb begin
        ld_real = '0;
        ld_imag = '0;
        for (int i = 0; i < N; i++) begin
            ld_real[DW*i +: DW] = (i == N - 1 && state == FILL) ? bus.s_real : wr_real[i];
            ld_imag[DW*i +: DW] = (i == N - 1 && state == FILL) ? bus.s_imag : wr_imag[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt             <= '0;
            bus.frame_real  <= '0;
            bus.frame_imag  <= '0;
            bus.frame_valid <= 1'b0;
            bus.frame_err   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                wr_real[i] <= '0;
                wr_imag[i] <= '0;
            end
        end else begin
            bus.frame_valid <= xfer_fill || xfer_hold;
            bus.frame_err   <= abort || misalign;
            if (accept) begin
                wr_real[cnt] <= bus.s_real;
                wr_imag[cnt] <= bus.s_imag;
                cnt          <= abort ? '0 : cnt + 1'b1;
            end
            if (xfer_fill || xfer_hold) begin
                bus.frame_real <= ld_real;
                bus.frame_imag <= ld_imag;
            end
        end
    end
endmodule

// File: tb/tb_fft16_input_loader.sv
// tb_fft16_input_loader: directed vectors against hand-computed frame contents.
module tb_fft16_input_loader;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int stalls = 0;
    int c1, c2;

    fft16_input_loader_if bus ();

    fft16_input_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] sl(input logic [16*24-1:0] v, input int k);
        return v[24*k +: 24];
    endfunction

    // Present one sample and return at the negedge after it is accepted.
    task automatic beat(input logic [23:0] r, input logic [23:0] im, input logic l);
        int w = 0;
        bus.s_valid = 1'b1;
        bus.s_real  = r;
        bus.s_imag  = im;
        bus.s_last  = l;
        while (!bus.s_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        stalls += w;
        if (w >= 50) check("beat_timeout", 32'(w), 32'd0);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.s_valid   = 1'b0;
        bus.s_real    = '0;
        bus.s_imag    = '0;
        bus.s_last    = 1'b0;
        bus.fft_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.s_ready), 32'd0);
        check("rst_fv", 32'(bus.frame_valid), 32'd0);
        check("rst_err", 32'(bus.frame_err), 32'd0);
        check("rst_data", 32'(|{bus.frame_real, bus.frame_imag}), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(bus.s_ready), 32'd1);

        // Test 1: single frame 1,2,3,4 repeated
        for (int i = 0; i < 16; i++) beat(24'((i % 4) + 1), 24'd0, i == 15);
        idle();
        check("t1_fv", 32'(bus.frame_valid), 32'd1);
        check("t1_err", 32'(bus.frame_err), 32'd0);
        check("t1_s0", 32'(sl(bus.frame_real, 0)), 32'd1);
        check("t1_s3", 32'(sl(bus.frame_real, 3)), 32'd4);
        check("t1_s15", 32'(sl(bus.frame_real, 15)), 32'd4);
        check("t1_imag", 32'(|bus.frame_imag), 32'd0);
        @(negedge clk);
        check("t1_fv_pulse", 32'(bus.frame_valid), 32'd0);

        // Test 2: back-to-back frames with s_valid held high
        stalls = 0;
        for (int i = 0; i < 32; i++) begin
            beat(i < 16 ? 24'((i % 4) + 1) : 24'(((i - 16) % 8) + 1), 24'd0, i == 15 || i == 31);
            if (i == 15) begin
                c1 = cyc;
                check("t2_fv1", 32'(bus.frame_valid), 32'd1);
            end
            if (i == 19) begin
                check("t2_fv_gap", 32'(bus.frame_valid), 32'd0);
                check("t2_hold_s15", 32'(sl(bus.frame_real, 15)), 32'd4);
            end
            if (i == 31) c2 = cyc;
        end
        idle();
        check("t2_fv2", 32'(bus.frame_valid), 32'd1);
        check("t2_spacing", 32'(c2 - c1), 32'd16);
        check("t2_stalls", 32'(stalls), 32'd0);
        check("t2_s7", 32'(sl(bus.frame_real, 7)), 32'd8);
        check("t2_s8", 32'(sl(bus.frame_real, 8)), 32'd1);
        check("t2_s15", 32'(sl(bus.frame_real, 15)), 32'd8);
        @(negedge clk);

        // Test 3: downstream back-pressure at beat 16
        for (int i = 0; i < 16; i++) begin
            if (i == 15) bus.fft_ready = 1'b0;
            beat(24'(i + 1), 24'(i + 32), i == 15);
        end
        bus.s_real = 24'd999;
        check("t3_fv_held", 32'(bus.frame_valid), 32'd0);
        check("t3_ready_held", 32'(bus.s_ready), 32'd0);
        check("t3_err", 32'(bus.frame_err), 32'd0);
        repeat (4) @(negedge clk);
        check("t3_ready_still", 32'(bus.s_ready), 32'd0);
        check("t3_fv_still", 32'(bus.frame_valid), 32'd0);
        check("t3_old_frame", 32'(sl(bus.frame_real, 15)), 32'd8);
        bus.fft_ready = 1'b1;
        idle();
        @(negedge clk);
        check("t3_fv", 32'(bus.frame_valid), 32'd1);
        check("t3_s0", 32'(sl(bus.frame_real, 0)), 32'd1);
        check("t3_s15", 32'(sl(bus.frame_real, 15)), 32'd16);
        check("t3_i15", 32'(sl(bus.frame_imag, 15)), 32'd47);
        check("t3_ready", 32'(bus.s_ready), 32'd1);
        @(negedge clk);
        check("t3_fv_pulse", 32'(bus.frame_valid), 32'd0);

        // Test 4: early s_last aborts the frame
        for (int i = 0; i < 6; i++) beat(24'(i + 70), 24'd0, i == 5);
        idle();
        check("t4_err", 32'(bus.frame_err), 32'd1);
        check("t4_fv", 32'(bus.frame_valid), 32'd0);
        @(negedge clk);
        check("t4_err_pulse", 32'(bus.frame_err), 32'd0);
        for (int i = 0; i < 16; i++) beat(24'(i + 100), 24'd0, i == 15);
        idle();
        check("t4_fv2", 32'(bus.frame_valid), 32'd1);
        check("t4_s0", 32'(sl(bus.frame_real, 0)), 32'd100);
        check("t4_s15", 32'(sl(bus.frame_real, 15)), 32'd115);
        check("t4_err2", 32'(bus.frame_err), 32'd0);
        @(negedge clk);

        // Test 5: reset mid-frame, then an all-ones frame
        for (int i = 0; i < 9; i++) beat(24'(i + 50), 24'(i + 60), 1'b0);
        idle();
        rst = 1'b0;
        @(negedge clk);
        check("t5_ready", 32'(bus.s_ready), 32'd0);
        check("t5_fv", 32'(bus.frame_valid), 32'd0);
        check("t5_cleared", 32'(|{bus.frame_real, bus.frame_imag}), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 16; i++) beat(24'hFFFFFF, 24'd0, i == 15);
        idle();
        check("t5_fv2", 32'(bus.frame_valid), 32'd1);
        check("t5_s0", 32'(sl(bus.frame_real, 0)), 32'hFFFFFF);
        check("t5_s8", 32'(sl(bus.frame_real, 8)), 32'hFFFFFF);
        check("t5_s15", 32'(sl(bus.frame_real, 15)), 32'hFFFFFF);
        check("t5_imag", 32'(|bus.frame_imag), 32'd0);
        check("t5_err", 32'(bus.frame_err), 32'd0);
        @(negedge clk);

        // Test 6: missing s_last still completes the frame but flags it
        for (int i = 0; i < 16; i++) beat(24'(i * 3), 24'(i), 1'b0);
        idle();
        check("t6_fv", 32'(bus.frame_valid), 32'd1);
        check("t6_err", 32'(bus.frame_err), 32'd1);
        check("t6_s5", 32'(sl(bus.frame_real, 5)), 32'd15);
        check("t6_s15", 32'(sl(bus.frame_real, 15)), 32'd45);
        check("t6_i9", 32'(sl(bus.frame_imag, 9)), 32'd9);
        @(negedge clk);
        check("t6_err_pulse", 32'(bus.frame_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
